// File: rtl/codec_pkg.sv
// rtl/codec_pkg.sv - shared defaults and sample types for the codec playback path
package codec_pkg;

  localparam int I2S_DATA_WIDTH = 24;
  localparam int I2S_SLOT_WIDTH = 32;
  localparam int I2S_BCLK_DIV   = 4;

  // Stereo pair at the default sample width, for users outside the serializer
  typedef struct packed {
    logic [I2S_DATA_WIDTH-1:0] left;
    logic [I2S_DATA_WIDTH-1:0] right;
  } stereo_sample_t;

endpackage

// File: rtl/i2s_clk_gen.sv
// rtl/i2s_clk_gen.sv - I2S bit/frame timing: divider, bit counter, bclk and pblrc
module i2s_clk_gen
  import codec_pkg::*;
#(
  parameter int SLOT_WIDTH = I2S_SLOT_WIDTH,
  parameter int BCLK_DIV   = I2S_BCLK_DIV,
  localparam int POS_W     = $clog2(SLOT_WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  output logic             frame_start,
  output logic             slot_right,
  output logic [POS_W-1:0] slot_pos,
  output logic             bclk,
  output logic             pblrc
);

  localparam int DIV_W = $clog2(BCLK_DIV);
  localparam int BIT_W = $clog2(2 * SLOT_WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_WIDTH - 1);
  localparam logic [BIT_W-1:0] SLOT_C   = BIT_W'(SLOT_WIDTH);

  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;

  // A frame starts whenever both counters sit at zero; this also covers the first enabled cycle
  assign frame_start = enable && (div_cnt == '0) && (bit_cnt == '0);
  assign slot_right  = (bit_cnt >= SLOT_C);
  assign slot_pos    = POS_W'(slot_right ? (bit_cnt - SLOT_C) : bit_cnt);

  // Clock divider and bit-in-frame counter; both parked at zero while disabled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (!enable) begin
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Registered pin outputs: bclk low in the first half of each bit, pblrc high in the right slot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk  <= 1'b0;
      pblrc <= 1'b0;
    end else begin
      bclk  <= enable && (div_cnt >= DIV_HALF);
      pblrc <= enable && slot_right;
    end
  end

endmodule

// File: rtl/i2s_playback_serializer.sv
// rtl/i2s_playback_serializer.sv - stereo sample handshake and I2S playback serializer
module i2s_playback_serializer
  import codec_pkg::*;
#(
  parameter int DATA_WIDTH = I2S_DATA_WIDTH,
  parameter int SLOT_WIDTH = I2S_SLOT_WIDTH,
  parameter int BCLK_DIV   = I2S_BCLK_DIV
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] s_left,
  input  logic [DATA_WIDTH-1:0] s_right,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  sample_req,
  output logic                  underrun,
  output logic                  bclk,
  output logic                  pblrc,
  output logic                  pbdat
);

  localparam int POS_W = $clog2(SLOT_WIDTH);
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  generate
    if (DATA_WIDTH < 1 || DATA_WIDTH > SLOT_WIDTH - 1) begin : g_bad_data_width
      $error("DATA_WIDTH must be in 1..SLOT_WIDTH-1");
    end
    if (BCLK_DIV < 2 || (BCLK_DIV % 2) != 0) begin : g_bad_bclk_div
      $error("BCLK_DIV must be even and at least 2");
    end
  endgenerate

  typedef struct packed {
    logic [DATA_WIDTH-1:0] left;
    logic [DATA_WIDTH-1:0] right;
  } pair_t;

  pair_t             holding;
  pair_t             active;
  logic              holding_full;
  logic              frame_start;
  logic              slot_right;
  logic [POS_W-1:0]  slot_pos;
  logic [DATA_WIDTH-1:0] sel;
  logic [IDX_W-1:0]  idx;
  logic              data_bit;

  assign s_ready = ~holding_full;

  i2s_clk_gen #(
    .SLOT_WIDTH (SLOT_WIDTH),
    .BCLK_DIV   (BCLK_DIV)
  ) u_clk_gen (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .frame_start (frame_start),
    .slot_right  (slot_right),
    .slot_pos    (slot_pos),
    .bclk        (bclk),
    .pblrc       (pblrc)
  );

  // Holding register fills on handshake; at a frame start its contents move to the active pair.
  // An accept coinciding with a frame start lands in holding and waits for the following frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      holding      <= '0;
      holding_full <= 1'b0;
      active       <= '0;
    end else begin
      if (!enable) begin
        active <= '0;
      end else if (frame_start) begin
        active <= holding_full ? holding : '0;
      end
      if (s_valid && !holding_full) begin
        holding      <= {s_left, s_right};
        holding_full <= 1'b1;
      end else if (frame_start && holding_full) begin
        holding_full <= 1'b0;
      end
    end
  end

  // Slot position 1..DATA_WIDTH carries the sample MSB first; position 0 gives the one-BCLK I2S delay
  always_comb begin
    sel      = slot_right ? active.right : active.left;
    idx      = '0;
    data_bit = 1'b0;
    if (int'(slot_pos) >= 1 && int'(slot_pos) <= DATA_WIDTH) begin
      idx      = IDX_W'(DATA_WIDTH - int'(slot_pos));
      data_bit = sel[idx];
    end
  end

  // Registered serial data and per-frame pulses, aligned with bclk/pblrc
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pbdat      <= 1'b0;
      sample_req <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      pbdat      <= enable && data_bit;
      sample_req <= frame_start;
      underrun   <= frame_start && !holding_full;
    end
  end

endmodule
